updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 74 +++++++
 tb/tb_updown_mod_counter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Modulo-MOD up/down counter with a configurable step and a saturating parallel load.
// wrap and load_err are one-cycle registered pulses. tc is a combinational look-ahead.
module updown_mod_counter #(
   parameter int WIDTH     = 4,
   parameter int MOD       = 16,
   parameter int STEP      = 1,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   if (MOD < 2 || MOD > (1 << WIDTH) || STEP < 1 || STEP >= MOD ||
       RESET_VAL < 0 || RESET_VAL >= MOD) begin : g_bad_params
      $fatal(1, "updown_mod_counter: illegal parameters WIDTH=%0d MOD=%0d STEP=%0d RESET_VAL=%0d",
             WIDTH, MOD, STEP, RESET_VAL);
   end

   // The modulus may equal 2^WIDTH, so the constants and all step arithmetic carry one extra bit.
   localparam logic [WIDTH:0]   MOD_C  = (WIDTH+1)'(MOD);
   localparam logic [WIDTH:0]   STEP_C = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0]   DN_C   = (WIDTH+1)'(MOD - STEP);
   localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] RST_C  = WIDTH'(RESET_VAL);

   logic [WIDTH:0]   cnt_ext;
   logic [WIDTH:0]   up_sum;
   logic             up_wrap;
   logic             dn_wrap;
   logic             load_ok;
   logic [WIDTH-1:0] step_val;

   always_comb begin
      cnt_ext = {1'b0, count};
      up_sum  = cnt_ext + STEP_C;
      up_wrap = (up_sum >= MOD_C);
      dn_wrap = (cnt_ext < STEP_C);
      load_ok = ({1'b0, load_val} < MOD_C);
      tc      = up ? up_wrap : dn_wrap;
      if (up)
         step_val = WIDTH'(up_wrap ? up_sum - MOD_C : up_sum);
      else
         step_val = WIDTH'(dn_wrap ? cnt_ext + DN_C : cnt_ext - STEP_C);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= RST_C;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else if (load) begin
         // Out-of-range loads saturate to the top of the range instead of being dropped.
         count    <= load_ok ? load_val : MAX_C;
         wrap     <= 1'b0;
         load_err <= ~load_ok;
      end else if (en) begin
         count    <= step_val;
         wrap     <= tc;
         load_err <= 1'b0;
      end else begin
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: two counters (STEP=1 and STEP=3, MOD=10) share one stimulus stream.
// The driver pushes model predictions. A monitor pops them and compares after each edge.
module tb_updown_mod_counter;

   localparam int W = 4;
   localparam int M = 10;

   logic         clk = 1'b0;
   logic         reset, en, up, load;
   logic [W-1:0] load_val;
   logic [W-1:0] count_a, count_b;
   logic         tc_a, tc_b, wrap_a, wrap_b, err_a, err_b;

   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(W), .MOD(M), .STEP(1), .RESET_VAL(0)) dut_a (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .count(count_a), .tc(tc_a), .wrap(wrap_a), .load_err(err_a));

   updown_mod_counter #(.WIDTH(W), .MOD(M), .STEP(3), .RESET_VAL(0)) dut_b (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .count(count_b), .tc(tc_b), .wrap(wrap_b), .load_err(err_b));

   typedef struct packed {
      logic [1:0][3:0] cnt;
      logic [1:0]      wr;
      logic [1:0]      le;
      logic [1:0]      tc;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   mc[2];
   int   steps[2] = '{1, 3};

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: plain modular arithmetic on integers.
   task automatic cyc(input bit r, input bit e, input bit u, input bit l, input int lv);
      exp_t x;
      @(negedge clk);
      reset = r; en = e; up = u; load = l; load_val = W'(lv);
      x = '0;
      for (int i = 0; i < 2; i++) begin
         int s;
         s = steps[i];
         if (r) begin
            mc[i] = 0;
         end else if (l) begin
            if (lv < M) mc[i] = lv;
            else begin
               mc[i]   = M - 1;
               x.le[i] = 1'b1;
            end
         end else if (e) begin
            if (u) begin
               x.wr[i] = (mc[i] + s >= M);
               mc[i]   = (mc[i] + s) % M;
            end else begin
               x.wr[i] = (mc[i] < s);
               mc[i]   = (mc[i] - s + M) % M;
            end
         end
         x.cnt[i] = 4'(mc[i]);
         x.tc[i]  = u ? (mc[i] + s >= M) : (mc[i] < s);
      end
      q.push_back(x);
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (q.size() > 0) begin
         x = q.pop_front();
         chk("count_a", int'(count_a), int'(x.cnt[0]));
         chk("wrap_a",  int'(wrap_a),  int'(x.wr[0]));
         chk("err_a",   int'(err_a),   int'(x.le[0]));
         chk("tc_a",    int'(tc_a),    int'(x.tc[0]));
         chk("count_b", int'(count_b), int'(x.cnt[1]));
         chk("wrap_b",  int'(wrap_b),  int'(x.wr[1]));
         chk("err_b",   int'(err_b),   int'(x.le[1]));
         chk("tc_b",    int'(tc_b),    int'(x.tc[1]));
      end
   end

   initial begin
      reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
      mc[0] = 0; mc[1] = 0;
      // Reset dominates an active load and enable.
      repeat (2) cyc(1, 1, 1, 1, 5);
      // Count up through a full wrap, then down across zero.
      repeat (10) cyc(0, 1, 1, 0, 0);
      repeat (2) cyc(0, 1, 0, 0, 0);
      // Loads win over enable; an out-of-range load saturates and flags once.
      cyc(0, 1, 1, 1, 7);
      cyc(0, 1, 1, 1, 12);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      // STEP=3 wrap in both directions.
      cyc(0, 0, 1, 1, 8);
      cyc(0, 1, 1, 0, 0);
      cyc(0, 0, 0, 1, 1);
      cyc(0, 1, 0, 0, 0);
      // Direction flips with no dead cycle.
      cyc(0, 1, 1, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 1, 0, 0);
      // Reset mid-count, then resume from zero.
      cyc(0, 0, 1, 1, 5);
      cyc(0, 1, 1, 0, 0);
      cyc(1, 1, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      // Reset on the edge after a wrap and a load error clears both pulses.
      cyc(0, 0, 1, 1, 9);
      cyc(0, 1, 1, 0, 0);
      cyc(1, 1, 1, 1, 15);
      cyc(0, 0, 1, 1, 15);
      cyc(1, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6), $urandom_range(0, 1),
             ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)));
      end
      cyc(0, 0, 1, 0, 0);
      for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
      #2;
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending entries expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
